// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: expands one 512-bit padded block into W0..W63
// with a 16-word sliding window, one word per w_valid/w_ready handshake.
module sha256_msg_schedule #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_data,
    output logic [5:0]   w_idx,
    output logic         w_first,
    output logic         w_last
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];
    logic [5:0]  t_q, t_d;
    logic        blk_hs;
    logic        w_hs;
    logic [31:0] new_word;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    assign w_valid   = (state_q == RUN);
    assign w_data    = win_q[0];
    assign w_idx     = t_q;
    assign w_first   = w_valid && (t_q == 6'd0);
    assign w_last    = w_valid && (t_q == 6'd63);
    // A new block may load on the same edge the terminal word is taken.
    assign blk_ready = (state_q == IDLE) || (w_last && w_ready);
    assign blk_hs    = blk_valid && blk_ready;
    assign w_hs      = w_valid && w_ready;
    assign new_word  = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        for (int i = 0; i < 16; i++) begin
            win_d[i] = win_q[i];
        end
        if (blk_hs) begin
            state_d = RUN;
            t_d     = 6'd0;
            for (int i = 0; i < 16; i++) begin
                win_d[i] = MSB_FIRST ? blk_data[511 - 32*i -: 32] : blk_data[32*i +: 32];
            end
        end else if (w_hs) begin
            for (int i = 0; i < 15; i++) begin
                win_d[i] = win_q[i + 1];
            end
            win_d[15] = new_word;
            if (t_q == 6'd63) begin
                state_d = IDLE;
            end else begin
                t_d = t_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            t_q     <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= 32'd0;
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule: known SHA-256 blocks, backpressure,
// back-to-back blocks, upstream hold-off and reset in the middle of a block.
module tb_sha256_msg_schedule;

    logic         clk;
    logic         rst_n;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_data;
    logic [5:0]   w_idx;
    logic         w_first;
    logic         w_last;

    int checks;
    int failures;

    localparam logic [511:0] ABC_BLK   = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, {15{32'h00000000}}};
    localparam logic [511:0] JUNK_BLK  = {16{32'hDEADBEEF}};

    logic [31:0] exp_w   [64];
    logic [31:0] got_w   [128];
    logic [5:0]  got_idx [128];
    int          ncycles;
    int          first_valid;
    int          last_cnt;
    int          first_cnt;
    int          hold_err;
    int          holdoff_err;
    int          hs_count;
    int          hs_at;
    bit          timed_out;

    sha256_msg_schedule #(.MSB_FIRST(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_idx     (w_idx),
        .w_first   (w_first),
        .w_last    (w_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ms0(input logic [31:0] x);
        return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ms1(input logic [31:0] x);
        return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
    endfunction

    // Reference: full 64-entry FIPS 180-4 schedule array.
    task automatic model_block(input logic [511:0] b);
        for (int i = 0; i < 16; i++) exp_w[i] = b[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            exp_w[i] = ms1(exp_w[i-2]) + exp_w[i-7] + ms0(exp_w[i-15]) + exp_w[i-16];
    endtask

    task automatic send_block(input logic [511:0] b, input bit keep, output bit ok);
        ok        = 1'b0;
        blk_valid = 1'b1;
        blk_data  = b;
        for (int k = 0; k < 200; k++) begin
            if (blk_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        if (!keep) blk_valid = 1'b0;
    endtask

    // Captures words at each handshake; mode 0 = always ready,
    // 1 = 5-cycle stall at t=20 then random ready, 2 = always ready with a
    // held-off upstream block presented from word 10.
    task automatic collect(input int mode, input int nwords);
        int   cyc;
        int   n;
        int   stall_cnt;
        bit   prev_stall;
        bit   drop;
        logic [31:0] prev_d;
        logic [5:0]  prev_i;
        n = 0; cyc = 0; stall_cnt = 0; prev_stall = 0; drop = 0;
        prev_d = '0; prev_i = '0;
        first_valid = -1; last_cnt = 0; first_cnt = 0; hold_err = 0;
        holdoff_err = 0; hs_count = 0; hs_at = -1; timed_out = 0;
        while (n < nwords) begin
            if (cyc >= 2000) begin
                timed_out = 1'b1;
                break;
            end
            if (drop) begin
                blk_valid = 1'b0;
                drop = 1'b0;
            end
            if (mode == 1) begin
                if (n == 20 && stall_cnt < 5) begin
                    w_ready = 1'b0;
                    stall_cnt++;
                end else if (n > 20) begin
                    w_ready = 1'($urandom_range(0, 1));
                end else begin
                    w_ready = 1'b1;
                end
            end else begin
                w_ready = 1'b1;
            end
            if (mode == 2 && hs_count == 0 && n >= 10) begin
                blk_valid = 1'b1;
                if (n >= 50)      blk_data = EMPTY_BLK;
                else if (n >= 30) blk_data = JUNK_BLK;
                else              blk_data = EMPTY_BLK;
            end
            #1;
            if (w_valid && prev_stall && (w_data !== prev_d || w_idx !== prev_i)) hold_err++;
            if (blk_valid && blk_ready && w_valid && !(w_idx == 6'd63 && w_ready)) holdoff_err++;
            if (blk_valid && blk_ready) begin
                hs_count++;
                hs_at = n;
                drop = 1'b1;
            end
            if (w_valid && first_valid < 0) first_valid = cyc;
            prev_stall = w_valid && !w_ready;
            prev_d = w_data;
            prev_i = w_idx;
            if (w_valid && w_ready) begin
                got_w[n]   = w_data;
                got_idx[n] = w_idx;
                if (w_last)  last_cnt++;
                if (w_first) first_cnt++;
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        if (drop) blk_valid = 1'b0;
        ncycles = cyc;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; blk_valid = 1'b0; blk_data = '0; w_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (w_valid !== 1'b0)   begin failures++; $display("[TB] FAIL reset_w_valid got=%b exp=0", w_valid); end
        checks++; if (blk_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_blk_ready got=%b exp=1", blk_ready); end
        checks++; if (w_idx !== 6'd0)     begin failures++; $display("[TB] FAIL reset_w_idx got=%0d exp=0", w_idx); end
        checks++; if (w_data !== 32'd0)   begin failures++; $display("[TB] FAIL reset_w_data got=%h exp=0", w_data); end
        checks++; if (w_first !== 1'b0 || w_last !== 1'b0) begin failures++; $display("[TB] FAIL reset_first_last got=%b%b exp=00", w_first, w_last); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (w_valid !== 1'b0 || blk_ready !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_idle got=%b%b exp=01", w_valid, blk_ready); end
    endtask

    task automatic test_abc;
        bit ok;
        model_block(ABC_BLK);
        w_ready = 1'b1;
        send_block(ABC_BLK, 1'b0, ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL abc_accept got=timeout exp=handshake"); end
        collect(0, 64);
        checks++; if (timed_out)        begin failures++; $display("[TB] FAIL abc_timeout got=%0d words exp=64", ncycles); end
        checks++; if (first_valid != 0) begin failures++; $display("[TB] FAIL abc_latency got=%0d exp=0", first_valid); end
        checks++; if (ncycles != 64)    begin failures++; $display("[TB] FAIL abc_cycles got=%0d exp=64", ncycles); end
        checks++; if (last_cnt != 1)    begin failures++; $display("[TB] FAIL abc_last_count got=%0d exp=1", last_cnt); end
        checks++; if (first_cnt != 1)   begin failures++; $display("[TB] FAIL abc_first_count got=%0d exp=1", first_cnt); end
        checks++; if (got_w[0]  !== 32'h61626380) begin failures++; $display("[TB] FAIL abc_w0 got=%h exp=61626380", got_w[0]); end
        checks++; if (got_w[15] !== 32'h00000018) begin failures++; $display("[TB] FAIL abc_w15 got=%h exp=00000018", got_w[15]); end
        checks++; if (got_w[16] !== 32'h61626380) begin failures++; $display("[TB] FAIL abc_w16 got=%h exp=61626380", got_w[16]); end
        checks++; if (got_w[17] !== 32'h000F0000) begin failures++; $display("[TB] FAIL abc_w17 got=%h exp=000f0000", got_w[17]); end
        checks++; if (got_w[63] !== 32'h12B1EDEB) begin failures++; $display("[TB] FAIL abc_w63 got=%h exp=12b1edeb", got_w[63]); end
        for (int i = 0; i < 64; i++) begin
            checks++; if (got_w[i] !== exp_w[i]) begin failures++; $display("[TB] FAIL abc_word t=%0d got=%h exp=%h", i, got_w[i], exp_w[i]); end
            checks++; if (got_idx[i] !== 6'(i))  begin failures++; $display("[TB] FAIL abc_idx n=%0d got=%0d exp=%0d", i, got_idx[i], i); end
        end
        checks++; if (w_valid !== 1'b0 || blk_ready !== 1'b1) begin failures++; $display("[TB] FAIL abc_back_idle got=%b%b exp=01", w_valid, blk_ready); end
    endtask

    task automatic test_empty;
        bit ok;
        int zeros_bad;
        model_block(EMPTY_BLK);
        send_block(EMPTY_BLK, 1'b0, ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL empty_accept got=timeout exp=handshake"); end
        collect(0, 64);
        checks++; if (timed_out) begin failures++; $display("[TB] FAIL empty_timeout got=%0d cycles exp=64 words", ncycles); end
        checks++; if (got_w[0] !== 32'h80000000) begin failures++; $display("[TB] FAIL empty_w0 got=%h exp=80000000", got_w[0]); end
        zeros_bad = 0;
        for (int i = 1; i < 16; i++) if (got_w[i] !== 32'd0) zeros_bad++;
        checks++; if (zeros_bad != 0) begin failures++; $display("[TB] FAIL empty_w1_15 got=%0d nonzero exp=0", zeros_bad); end
        checks++; if (got_w[16] !== 32'h80000000) begin failures++; $display("[TB] FAIL empty_w16 got=%h exp=80000000", got_w[16]); end
        checks++; if (got_w[17] !== 32'h00000000) begin failures++; $display("[TB] FAIL empty_w17 got=%h exp=00000000", got_w[17]); end
        for (int i = 0; i < 64; i++) begin
            checks++; if (got_w[i] !== exp_w[i]) begin failures++; $display("[TB] FAIL empty_word t=%0d got=%h exp=%h", i, got_w[i], exp_w[i]); end
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        model_block(ABC_BLK);
        send_block(ABC_BLK, 1'b0, ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL bp_accept got=timeout exp=handshake"); end
        collect(1, 64);
        w_ready = 1'b1;
        checks++; if (timed_out)    begin failures++; $display("[TB] FAIL bp_timeout got=%0d cycles exp=64 words", ncycles); end
        checks++; if (hold_err != 0) begin failures++; $display("[TB] FAIL bp_hold got=%0d changes exp=0", hold_err); end
        checks++; if (ncycles < 69)  begin failures++; $display("[TB] FAIL bp_stalled got=%0d cycles exp>=69", ncycles); end
        checks++; if (last_cnt != 1) begin failures++; $display("[TB] FAIL bp_last_count got=%0d exp=1", last_cnt); end
        for (int i = 0; i < 64; i++) begin
            checks++; if (got_w[i] !== exp_w[i]) begin failures++; $display("[TB] FAIL bp_word t=%0d got=%h exp=%h", i, got_w[i], exp_w[i]); end
            checks++; if (got_idx[i] !== 6'(i))  begin failures++; $display("[TB] FAIL bp_idx n=%0d got=%0d exp=%0d", i, got_idx[i], i); end
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        w_ready = 1'b1;
        send_block(ABC_BLK, 1'b1, ok);
        blk_data = EMPTY_BLK;
        checks++; if (!ok) begin failures++; $display("[TB] FAIL b2b_accept got=timeout exp=handshake"); end
        collect(0, 128);
        checks++; if (timed_out)     begin failures++; $display("[TB] FAIL b2b_timeout got=%0d cycles exp=128 words", ncycles); end
        checks++; if (ncycles != 128) begin failures++; $display("[TB] FAIL b2b_gap got=%0d cycles exp=128", ncycles); end
        checks++; if (hs_count != 1 || hs_at != 63) begin failures++; $display("[TB] FAIL b2b_accept_edge got=%0d@%0d exp=1@63", hs_count, hs_at); end
        checks++; if (got_idx[63] !== 6'd63 || got_idx[64] !== 6'd0) begin failures++; $display("[TB] FAIL b2b_wrap got=%0d,%0d exp=63,0", got_idx[63], got_idx[64]); end
        model_block(ABC_BLK);
        for (int i = 0; i < 64; i++) begin
            checks++; if (got_w[i] !== exp_w[i]) begin failures++; $display("[TB] FAIL b2b_first_word t=%0d got=%h exp=%h", i, got_w[i], exp_w[i]); end
        end
        model_block(EMPTY_BLK);
        for (int i = 0; i < 64; i++) begin
            checks++; if (got_w[64+i] !== exp_w[i]) begin failures++; $display("[TB] FAIL b2b_second_word t=%0d got=%h exp=%h", i, got_w[64+i], exp_w[i]); end
            checks++; if (got_idx[64+i] !== 6'(i))  begin failures++; $display("[TB] FAIL b2b_second_idx n=%0d got=%0d exp=%0d", i, got_idx[64+i], i); end
        end
        checks++; if (w_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_end_idle got=%b exp=0", w_valid); end
    endtask

    task automatic test_holdoff;
        bit ok;
        send_block(ABC_BLK, 1'b0, ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL hold_accept got=timeout exp=handshake"); end
        collect(2, 128);
        checks++; if (timed_out)        begin failures++; $display("[TB] FAIL hold_timeout got=%0d cycles exp=128 words", ncycles); end
        checks++; if (holdoff_err != 0) begin failures++; $display("[TB] FAIL hold_early_ready got=%0d exp=0", holdoff_err); end
        checks++; if (hs_count != 1 || hs_at != 63) begin failures++; $display("[TB] FAIL hold_accept_edge got=%0d@%0d exp=1@63", hs_count, hs_at); end
        model_block(ABC_BLK);
        for (int i = 0; i < 64; i++) begin
            checks++; if (got_w[i] !== exp_w[i]) begin failures++; $display("[TB] FAIL hold_cur_word t=%0d got=%h exp=%h", i, got_w[i], exp_w[i]); end
        end
        model_block(EMPTY_BLK);
        for (int i = 0; i < 64; i++) begin
            checks++; if (got_w[64+i] !== exp_w[i]) begin failures++; $display("[TB] FAIL hold_next_word t=%0d got=%h exp=%h", i, got_w[64+i], exp_w[i]); end
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        send_block(ABC_BLK, 1'b0, ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL rmid_accept got=timeout exp=handshake"); end
        collect(0, 30);
        checks++; if (w_idx !== 6'd30) begin failures++; $display("[TB] FAIL rmid_pre_idx got=%0d exp=30", w_idx); end
        rst_n = 1'b0;
        #1;
        checks++; if (w_valid !== 1'b0)   begin failures++; $display("[TB] FAIL rmid_w_valid got=%b exp=0", w_valid); end
        checks++; if (w_idx !== 6'd0 || w_data !== 32'd0) begin failures++; $display("[TB] FAIL rmid_clear got=%0d/%h exp=0/0", w_idx, w_data); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (w_valid !== 1'b0 || blk_ready !== 1'b1) begin failures++; $display("[TB] FAIL rmid_release got=%b%b exp=01", w_valid, blk_ready); end
        model_block(EMPTY_BLK);
        send_block(EMPTY_BLK, 1'b0, ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL rmid_next_accept got=timeout exp=handshake"); end
        collect(0, 64);
        checks++; if (timed_out) begin failures++; $display("[TB] FAIL rmid_timeout got=%0d cycles exp=64 words", ncycles); end
        for (int i = 0; i < 64; i++) begin
            checks++; if (got_w[i] !== exp_w[i]) begin failures++; $display("[TB] FAIL rmid_word t=%0d got=%h exp=%h", i, got_w[i], exp_w[i]); end
            checks++; if (got_idx[i] !== 6'(i))  begin failures++; $display("[TB] FAIL rmid_idx n=%0d got=%0d exp=%0d", i, got_idx[i], i); end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_abc();
        test_empty();
        test_backpressure();
        test_back_to_back();
        test_holdoff();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
